// File: rtl/rs_pkg.sv
// Shared types for the reservation-station issue queue: producer tags, queue entries
// and the CDB tag compare used by both the alloc bypass and per-entry wakeup.
package rs_pkg;

   localparam int unsigned RS_TAG_W     = 3;
   localparam int unsigned RS_DATA_W    = 32;
   localparam int unsigned RS_PAYLOAD_W = 24;

   typedef struct packed {
      logic                busy;
      logic [RS_TAG_W-1:0] idx;
   } tag_t;

   typedef struct packed {
      logic                    valid;
      logic [RS_PAYLOAD_W-1:0] payload;
      logic [RS_TAG_W-1:0]     dest;
      tag_t                    qj;
      tag_t                    qk;
      tag_t                    qf;
      logic [RS_DATA_W-1:0]    vj;
      logic [RS_DATA_W-1:0]    vk;
   } entry_t;

   // A pending operand is satisfied by a valid broadcast carrying its producer index
   function automatic logic tag_match(input tag_t                t,
                                      input logic                cdb_valid,
                                      input logic [RS_TAG_W-1:0] cdb_tag);
      return t.busy & cdb_valid & (t.idx == cdb_tag);
   endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: picks its next content (alloc, upper neighbour or
// itself), applies CDB wakeup to that content and reports readiness.
module rs_entry
   import rs_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   input  logic                i_load,
   input  logic                i_shift,
   input  entry_t              i_alloc,
   input  entry_t              i_upper,
   input  logic                i_cdb_valid,
   input  logic [RS_TAG_W-1:0] i_cdb_tag,
   input  logic [RS_DATA_W-1:0] i_cdb_data,
   input  logic                i_flag_valid,
   input  logic [RS_TAG_W-1:0] i_flag_tag,
   output entry_t              o_entry,
   output logic                o_ready_c
);

   entry_t r_entry;
   entry_t w_src;
   entry_t w_next;

   // Wakeup follows the content wherever it lands, so shifted entries keep their captures
   always_comb begin
      w_src = r_entry;
      if (i_load) begin
         w_src = i_alloc;
      end else if (i_shift) begin
         w_src = i_upper;
      end
      w_next = w_src;
      if (tag_match(w_src.qj, i_cdb_valid, i_cdb_tag)) begin
         w_next.qj.busy = 1'b0;
         w_next.vj      = i_cdb_data;
      end
      if (tag_match(w_src.qk, i_cdb_valid, i_cdb_tag)) begin
         w_next.qk.busy = 1'b0;
         w_next.vk      = i_cdb_data;
      end
      if (tag_match(w_src.qf, i_flag_valid, i_flag_tag)) begin
         w_next.qf.busy = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_entry <= '0;
      end else if (i_flush) begin
         r_entry <= '0;
      end else begin
         r_entry <= w_next;
      end
   end

   assign o_entry   = r_entry;
   assign o_ready_c = r_entry.valid & ~r_entry.qj.busy & ~r_entry.qk.busy & ~r_entry.qf.busy;

endmodule

// File: rtl/rs_issue_queue.sv
// Age-ordered collapsing reservation station: slot 0 is oldest, the oldest ready
// entry is moved into a registered valid/ready output stage.
module rs_issue_queue
   import rs_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned TAG_W     = RS_TAG_W,
   parameter int unsigned DATA_W    = RS_DATA_W,
   parameter int unsigned PAYLOAD_W = RS_PAYLOAD_W
) (
   input  logic                         CLK,
   input  logic                         Reset,
   input  logic                         Flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PAYLOAD_W-1:0]         in_payload,
   input  logic [TAG_W-1:0]             in_dest,
   input  logic                         in_qj_busy,
   input  logic                         in_qk_busy,
   input  logic                         in_qf_busy,
   input  logic [TAG_W-1:0]             in_qj,
   input  logic [TAG_W-1:0]             in_qk,
   input  logic [TAG_W-1:0]             in_qf,
   input  logic [DATA_W-1:0]            in_vj,
   input  logic [DATA_W-1:0]            in_vk,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [DATA_W-1:0]            cdb_data,
   input  logic                         cdb_flag_valid,
   input  logic [TAG_W-1:0]             cdb_flag_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PAYLOAD_W-1:0]         out_payload,
   output logic [TAG_W-1:0]             out_dest,
   output logic [DATA_W-1:0]            out_srca,
   output logic [DATA_W-1:0]            out_srcb,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [CNT_W-1:0]     r_count;
   logic                 r_out_valid;
   logic [PAYLOAD_W-1:0] r_out_payload;
   logic [TAG_W-1:0]     r_out_dest;
   logic [DATA_W-1:0]    r_out_srca;
   logic [DATA_W-1:0]    r_out_srcb;

   entry_t               w_slot [DEPTH];
   entry_t               w_alloc_entry;
   entry_t               w_sel_entry;
   logic [DEPTH-1:0]     w_rdy;
   logic [DEPTH-1:0]     w_load_slot;
   logic [DEPTH-1:0]     w_shift_slot;
   logic [IDX_W-1:0]     w_sel;
   logic                 w_any_ready;
   logic                 w_alloc;
   logic                 w_dispatch;
   logic [CNT_W-1:0]     w_alloc_idx;

   assign in_ready    = (r_count != CNT_W'(DEPTH));
   assign w_alloc     = in_valid & in_ready & ~Flush;
   assign w_dispatch  = (~r_out_valid | out_ready) & w_any_ready & ~Flush;
   assign w_alloc_idx = r_count - CNT_W'(w_dispatch);

   always_comb begin
      w_alloc_entry         = '0;
      w_alloc_entry.valid   = 1'b1;
      w_alloc_entry.payload = in_payload;
      w_alloc_entry.dest    = in_dest;
      w_alloc_entry.qj.busy = in_qj_busy;
      w_alloc_entry.qj.idx  = in_qj;
      w_alloc_entry.qk.busy = in_qk_busy;
      w_alloc_entry.qk.idx  = in_qk;
      w_alloc_entry.qf.busy = in_qf_busy;
      w_alloc_entry.qf.idx  = in_qf;
      w_alloc_entry.vj      = in_vj;
      w_alloc_entry.vk      = in_vk;
   end

   // Oldest-first pick: scanning downwards leaves the lowest ready index
   always_comb begin
      w_any_ready = 1'b0;
      w_sel       = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (w_rdy[i]) begin
            w_any_ready = 1'b1;
            w_sel       = IDX_W'(i);
         end
      end
   end

   assign w_sel_entry = w_slot[w_sel];

   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_slot
      entry_t w_upper;
      if (g == int'(DEPTH) - 1) begin : g_last
         assign w_upper = '0;
      end else begin : g_mid
         assign w_upper = w_slot[g+1];
      end
      assign w_load_slot[g]  = w_alloc & (w_alloc_idx == CNT_W'(g));
      assign w_shift_slot[g] = w_dispatch & (CNT_W'(g) >= CNT_W'(w_sel));

      rs_entry u_entry (
         .i_clk        (CLK),
         .i_rst        (Reset),
         .i_flush      (Flush),
         .i_load       (w_load_slot[g]),
         .i_shift      (w_shift_slot[g]),
         .i_alloc      (w_alloc_entry),
         .i_upper      (w_upper),
         .i_cdb_valid  (cdb_valid),
         .i_cdb_tag    (cdb_tag),
         .i_cdb_data   (cdb_data),
         .i_flag_valid (cdb_flag_valid),
         .i_flag_tag   (cdb_flag_tag),
         .o_entry      (w_slot[g]),
         .o_ready_c    (w_rdy[g])
      );
   end

   // Occupancy and the output stage; a stalled output holds every field
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_count       <= '0;
         r_out_valid   <= 1'b0;
         r_out_payload <= '0;
         r_out_dest    <= '0;
         r_out_srca    <= '0;
         r_out_srcb    <= '0;
      end else if (Flush) begin
         r_count       <= '0;
         r_out_valid   <= 1'b0;
         r_out_payload <= '0;
         r_out_dest    <= '0;
         r_out_srca    <= '0;
         r_out_srcb    <= '0;
      end else begin
         r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_dispatch);
         if (w_dispatch) begin
            r_out_valid   <= 1'b1;
            r_out_payload <= w_sel_entry.payload;
            r_out_dest    <= w_sel_entry.dest;
            r_out_srca    <= w_sel_entry.vj;
            r_out_srcb    <= w_sel_entry.vk;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign count       = r_count;
   assign out_valid   = r_out_valid;
   assign out_payload = r_out_payload;
   assign out_dest    = r_out_dest;
   assign out_srca    = r_out_srca;
   assign out_srcb    = r_out_srcb;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed table-driven bench for rs_issue_queue plus hand-written full, flush and
// asynchronous-reset sequences.
module tb_rs_issue_queue;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        Flush;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_payload;
   logic [2:0]  in_dest;
   logic        in_qj_busy, in_qk_busy, in_qf_busy;
   logic [2:0]  in_qj, in_qk, in_qf;
   logic [31:0] in_vj, in_vk;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        cdb_flag_valid;
   logic [2:0]  cdb_flag_tag;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_payload;
   logic [2:0]  out_dest;
   logic [31:0] out_srca, out_srcb;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   rs_issue_queue #(.DEPTH(4), .TAG_W(3), .DATA_W(32), .PAYLOAD_W(24)) dut (
      .CLK(CLK), .Reset(Reset), .Flush(Flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload), .in_dest(in_dest),
      .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy), .in_qf_busy(in_qf_busy),
      .in_qj(in_qj), .in_qk(in_qk), .in_qf(in_qf), .in_vj(in_vj), .in_vk(in_vk),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_flag_valid(cdb_flag_valid), .cdb_flag_tag(cdb_flag_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
      .out_dest(out_dest), .out_srca(out_srca), .out_srcb(out_srcb), .count(count)
   );

   // Tags in the table are {busy, idx}: 4'hC = busy on 4, 4'h9 = busy on 1, etc.
   typedef struct {
      logic        iv;
      logic [23:0] pl;
      logic [2:0]  dest;
      logic [3:0]  qj, qk, qf;
      logic [31:0] vj, vk;
      logic        cv;
      logic [2:0]  ct;
      logic [31:0] cd;
      logic        fv;
      logic [2:0]  ft;
      logic        e_ov;
      logic [2:0]  e_dest;
      logic [31:0] e_a, e_b;
      logic [23:0] e_pl;
      logic [2:0]  e_cnt;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mk(logic iv, logic [23:0] pl, logic [2:0] dest, logic [3:0] qj, logic [3:0] qk,
                               logic [3:0] qf, logic [31:0] vj, logic [31:0] vk, logic cv, logic [2:0] ct,
                               logic [31:0] cd, logic fv, logic [2:0] ft, logic e_ov, logic [2:0] e_dest,
                               logic [31:0] e_a, logic [31:0] e_b, logic [23:0] e_pl, logic [2:0] e_cnt);
      vec_t v;
      v.iv = iv; v.pl = pl; v.dest = dest; v.qj = qj; v.qk = qk; v.qf = qf; v.vj = vj; v.vk = vk;
      v.cv = cv; v.ct = ct; v.cd = cd; v.fv = fv; v.ft = ft;
      v.e_ov = e_ov; v.e_dest = e_dest; v.e_a = e_a; v.e_b = e_b; v.e_pl = e_pl; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_payload = '0; in_dest = '0;
      in_qj_busy = 1'b0; in_qk_busy = 1'b0; in_qf_busy = 1'b0;
      in_qj = '0; in_qk = '0; in_qf = '0; in_vj = '0; in_vk = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
      cdb_flag_valid = 1'b0; cdb_flag_tag = '0; Flush = 1'b0;
   endtask

   task automatic drive_alloc(input logic [23:0] pl, input logic [2:0] dest, input logic [3:0] qj,
                              input logic [31:0] vj, input logic [31:0] vk);
      in_valid = 1'b1; in_payload = pl; in_dest = dest;
      in_qj_busy = qj[3]; in_qj = qj[2:0];
      in_qk_busy = 1'b0; in_qf_busy = 1'b0; in_vj = vj; in_vk = vk;
   endtask

   task automatic apply(input vec_t v);
      in_valid = v.iv; in_payload = v.pl; in_dest = v.dest;
      in_qj_busy = v.qj[3]; in_qj = v.qj[2:0];
      in_qk_busy = v.qk[3]; in_qk = v.qk[2:0];
      in_qf_busy = v.qf[3]; in_qf = v.qf[2:0];
      in_vj = v.vj; in_vk = v.vk;
      cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd;
      cdb_flag_valid = v.fv; cdb_flag_tag = v.ft;
      Flush = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      // Row: inputs for one cycle, then outputs expected just after that cycle's edge
      vecs[0]  = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     0);
      vecs[1]  = mk(1, 24'h000A01, 2, 4'h0, 4'h0, 4'h0, 32'h5,  32'h7,    0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     1);
      vecs[2]  = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 1, 2, 32'h5,    32'h7,  24'h000A01, 0);
      vecs[3]  = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     0);
      vecs[4]  = mk(1, 24'h0000A1, 1, 4'hC, 4'h0, 4'h0, 32'h0,  32'h11,   0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     1);
      vecs[5]  = mk(1, 24'h0000B2, 3, 4'h0, 4'h0, 4'h0, 32'h21, 32'h22,   0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     2);
      vecs[6]  = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 1, 3, 32'h21,   32'h22, 24'h0000B2, 1);
      vecs[7]  = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    1, 4, 32'h1234, 0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     1);
      vecs[8]  = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 1, 1, 32'h1234, 32'h11, 24'h0000A1, 0);
      vecs[9]  = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     0);
      vecs[10] = mk(1, 24'h0000C3, 5, 4'h0, 4'hB, 4'h0, 32'h3,  32'hDEAD, 1, 3, 32'h9,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     1);
      vecs[11] = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 1, 5, 32'h3,    32'h9,  24'h0000C3, 0);
      vecs[12] = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     0);
      vecs[13] = mk(1, 24'h0000D4, 0, 4'h9, 4'h0, 4'h0, 32'h0,  32'h40,   0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     1);
      vecs[14] = mk(1, 24'h0000E5, 6, 4'h0, 4'h9, 4'hE, 32'h50, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     2);
      vecs[15] = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    1, 1, 32'h77,   1, 5, 0, 0, 32'h0,    32'h0,  24'h0,     2);
      vecs[16] = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 1, 0, 32'h77,   32'h40, 24'h0000D4, 1);
      vecs[17] = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    1, 6, 32'hBAD,  0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     1);
      vecs[18] = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    1, 6, 0, 0, 32'h0,    32'h0,  24'h0,     1);
      vecs[19] = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 1, 6, 32'h50,   32'h77, 24'h0000E5, 0);
      vecs[20] = mk(0, 24'h0,     0, 4'h0, 4'h0, 4'h0, 32'h0,  32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    32'h0,  24'h0,     0);

      idle_inputs();
      out_ready = 1'b1;
      Reset = 1'b1;
      tick();
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.count", 64'(count), 64'd0);
      chk("reset.in_ready", 64'(in_ready), 64'd1);
      tick();
      Reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         apply(vecs[i]);
         tick();
         chk($sformatf("v%0d.count", i), 64'(count), 64'(vecs[i].e_cnt));
         chk($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].e_cnt != 3'd4));
         chk($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
         if (vecs[i].e_ov) begin
            chk($sformatf("v%0d.dest", i), 64'(out_dest), 64'(vecs[i].e_dest));
            chk($sformatf("v%0d.srca", i), 64'(out_srca), 64'(vecs[i].e_a));
            chk($sformatf("v%0d.srcb", i), 64'(out_srcb), 64'(vecs[i].e_b));
            chk($sformatf("v%0d.payload", i), 64'(out_payload), 64'(vecs[i].e_pl));
         end
      end

      // Fill with the output stalled: first entry parks in the output stage, four more fill the queue
      idle_inputs();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_alloc(24'(32'h10 + k), 3'(k), 4'h0, 32'h100 + 32'(k), 32'h200 + 32'(k));
         tick();
         chk($sformatf("fill%0d.count", k), 64'(count), (k == 0) ? 64'd1 : 64'(k));
      end
      chk("fill.in_ready", 64'(in_ready), 64'd0);
      drive_alloc(24'h77, 3'd7, 4'h0, 32'h700, 32'h701);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("hold%0d.out_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("hold%0d.payload", k), 64'(out_payload), 64'h10);
         chk($sformatf("hold%0d.dest", k), 64'(out_dest), 64'd0);
         chk($sformatf("hold%0d.count", k), 64'(count), 64'd4);
      end
      out_ready = 1'b1;
      tick();
      chk("drain1.dest", 64'(out_dest), 64'd1);
      chk("drain1.payload", 64'(out_payload), 64'h11);
      chk("drain1.count", 64'(count), 64'd3);
      chk("drain1.in_ready", 64'(in_ready), 64'd1);
      idle_inputs();
      for (int k = 2; k < 5; k++) begin
         tick();
         chk($sformatf("drain%0d.out_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("drain%0d.dest", k), 64'(out_dest), 64'(k));
         chk($sformatf("drain%0d.srca", k), 64'(out_srca), 64'h100 + 64'(k));
         chk($sformatf("drain%0d.count", k), 64'(count), 64'(4 - k));
      end
      tick();
      chk("drain.empty_valid", 64'(out_valid), 64'd0);

      // Flush with three waiting entries and a stalled output
      out_ready = 1'b0;
      drive_alloc(24'h40, 3'd4, 4'h0, 32'hAA, 32'hBB);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive_alloc(24'h50 + 24'(k), 3'(k), 4'hF, 32'h0, 32'h0);
         tick();
      end
      chk("preflush.count", 64'(count), 64'd3);
      chk("preflush.out_valid", 64'(out_valid), 64'd1);
      drive_alloc(24'h66, 3'd6, 4'h0, 32'h6, 32'h6);
      Flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 32'hFF;
      tick();
      chk("flush.count", 64'(count), 64'd0);
      chk("flush.out_valid", 64'(out_valid), 64'd0);
      chk("flush.in_ready", 64'(in_ready), 64'd1);
      idle_inputs();
      out_ready = 1'b1;
      tick();
      chk("postflush.out_valid", 64'(out_valid), 64'd0);
      chk("postflush.count", 64'(count), 64'd0);

      // Asynchronous reset while an entry sits in the output stage and another waits
      drive_alloc(24'h4C, 3'd4, 4'h0, 32'h4A, 32'h4B);
      tick();
      drive_alloc(24'h5C, 3'd5, 4'hA, 32'h0, 32'h5B);
      tick();
      idle_inputs();
      out_ready = 1'b0;
      chk("prereset.out_valid", 64'(out_valid), 64'd1);
      chk("prereset.dest", 64'(out_dest), 64'd4);
      chk("prereset.srca", 64'(out_srca), 64'h4A);
      chk("prereset.count", 64'(count), 64'd1);
      #2;
      Reset = 1'b1;
      #1;
      chk("areset.out_valid", 64'(out_valid), 64'd0);
      chk("areset.dest", 64'(out_dest), 64'd0);
      chk("areset.srca", 64'(out_srca), 64'd0);
      chk("areset.srcb", 64'(out_srcb), 64'd0);
      chk("areset.payload", 64'(out_payload), 64'd0);
      chk("areset.count", 64'(count), 64'd0);
      chk("areset.in_ready", 64'(in_ready), 64'd1);
      tick();
      Reset = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("after_reset.out_valid", 64'(out_valid), 64'd0);
      chk("after_reset.count", 64'(count), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- Parametrised, age-ordered reservation station for one execution unit class (DP, MEM, MUL or FP); one instance per class.
- Accepts renamed instructions from issue, captures operands and flag readiness from the CDB, and dispatches the oldest ready entry through a registered valid/ready output stage.
- An entry frees at dispatch, not at CDB write-back. A Flush input clears every entry.

Parameters:
- DEPTH, 4, number of entries (>=2).
- TAG_W, 3, ROB index width. Tags carry an extra valid bit: {busy, index}.
- DATA_W, 32, operand width.
- PAYLOAD_W, 24, opaque control bundle passed through unchanged (Op, Cond, FlagW, RegW, NoWrite, Shamt5, Sh, ALUSrc).

Ports:
- CLK  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- Flush  in  1  synchronous clear of all entries and the output stage
- in_valid  in  1  issue request
- in_ready  out  1  = ~full; independent of in_valid and of dispatch
- in_payload  in  PAYLOAD_W  control bundle
- in_dest  in  TAG_W  destination ROB index
- in_qj_busy, in_qk_busy, in_qf_busy  in  1 each  operand A / operand B / flags still pending
- in_qj, in_qk, in_qf  in  TAG_W each  producer ROB indices
- in_vj, in_vk  in  DATA_W each  operand values (immediate already muxed into in_vk)
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  producing ROB index
- cdb_data  in  DATA_W  result value
- cdb_flag_valid  in  1  flag broadcast valid
- cdb_flag_tag  in  TAG_W  flag producer index
- out_valid  out  1  dispatch valid
- out_ready  in  1  execution unit accepts
- out_payload  out  PAYLOAD_W
- out_dest  out  TAG_W
- out_srca, out_srcb  out  DATA_W each
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset: all entries invalid, count=0, in_ready=1, out_valid=0, out_payload, out_dest, out_srca and out_srcb all 0.
- Storage is a collapsing queue: index 0 is oldest. An allocation writes to slot count (after any collapse in the same cycle).
- Alloc fires when in_valid & in_ready.
- Alloc-cycle CDB bypass: if cdb_valid and cdb_tag matches a pending in_qj or in_qk, that operand is stored ready with cdb_data. The same applies to flags via cdb_flag_valid/cdb_flag_tag.
- Wakeup: each valid entry compares its pending tags against the CDB every cycle and captures cdb_data. One CDB value may wake several entries and both operands of one entry.
- An entry is ready when it is valid and none of qj, qk or qf is pending. Ready is computed from registered state only, so an entry woken in cycle N is selectable in cycle N+1.
- Selection: lowest-index ready entry.
- Output stage: a single register. It loads when (~out_valid | out_ready) and a ready entry exists.
  - The selected entry is removed in that same cycle; younger entries shift down by one, keeping their in-flight wakeups.
  - If no entry is ready and out_ready=1, out_valid drops to 0.
  - Hold: while out_valid & ~out_ready, all outputs stay stable.
- Latency: an entry allocated fully ready in cycle N is selected in N+1 and appears with out_valid=1 in N+2.
- Throughput: one dispatch per cycle.
- Full case: in_ready=0 when count==DEPTH, even if a dispatch occurs in that cycle (no same-cycle refill).
- Simultaneous alloc+dispatch: count is unchanged; the new entry lands at slot count-1.
- Flush: has priority over alloc, wakeup and dispatch. Next cycle count=0 and out_valid=0. The CDB is ignored in the flush cycle.
- Reset mid-operation: immediate clear to the reset state regardless of CLK.
- A CDB tag equal to an entry's in_dest has no effect (no self-wakeup).

Decomposition:
- Shared package rs_pkg holds:
  - tag typedef {busy, index[TAG_W-1:0]};
  - entry struct {valid, payload, dest, qj, qk, qf, vj, vk};
  - function tag_match(tag, cdb_valid, cdb_tag).
- Sub-module rs_entry: one slot. Handles wakeup compare, capture, shift-in from the neighbour or from the alloc port, and emits ready. rs_issue_queue instantiates DEPTH rs_entry slots plus the select and output stage.

Test Plan:
- Alloc with qj and qk not busy, vj=5, vk=7, dest=2, out_ready=1 -> out_valid in cycle+2 with srca=5, srcb=7, dest=2; count back to 0.
- Alloc A (qj busy, tag 4), then B (ready) -> B dispatches first. CDB tag=4, data=0x1234 -> A dispatches 2 cycles later with srca=0x1234.
- Alloc with qk busy tag 3 while cdb_valid, tag=3, data=9 in the same cycle -> entry stores vk=9, dispatches at +2 with no further CDB needed.
- Fill DEPTH=4 with out_ready=0 -> in_ready=0 and count=4; out_payload is held stable for 5 cycles. Raise out_ready -> one dispatch per cycle, oldest first, and in_ready returns the cycle after the first dispatch.
- Two entries waiting on tag 1 (one on qj, one on qk), with the flag pending on tag 6 -> CDB tag 1 wakes both operands. The flag-pending entry waits until cdb_flag_tag=6.
- Three entries plus out_valid=1, then assert Flush -> next cycle count=0, out_valid=0, in_ready=1. Assert Reset asynchronously mid-dispatch -> outputs go to 0 immediately.
